// File: rtl/ssd_scan_controller.sv
// Multiplexed seven-segment scan controller with a double-buffered BCD word.
// Define SSD_LEADING_ZERO_BLANK_EN to darken leading-zero digit slots.
module ssd_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    upd_valid,
    input  logic [4*NUM_DIGITS-1:0] upd_data,
    output logic                    upd_ready,
    output logic [3:0]              bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_done
);

    localparam int DW = 4 * NUM_DIGITS;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    localparam logic [RW-1:0] RMAX = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BMAX = BW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IMAX = IW'(NUM_DIGITS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BLANK = 2'd1;
    localparam logic [1:0] SHOW  = 2'd2;

    logic [1:0]            state, state_n;
    logic [IW-1:0]         idx, idx_n;
    logic [BW-1:0]         bcnt, bcnt_n;
    logic [RW-1:0]         rcnt, rcnt_n;
    logic [DW-1:0]         active, active_n;
    logic [DW-1:0]         pending, pending_n;
    logic                  pending_full, pf_n;
    logic                  accept, xfer;
    logic [3:0]            nib_n;
    logic [NUM_DIGITS-1:0] en_n;
    logic                  fd_n;
`ifdef SSD_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] dark;
    logic                  zr;
`endif

    always_comb begin
        state_n = state;
        idx_n   = idx;
        bcnt_n  = bcnt;
        rcnt_n  = rcnt;
        if (!enable) begin
            state_n = IDLE;
            idx_n   = '0;
            bcnt_n  = '0;
            rcnt_n  = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = BLANK;
                    idx_n   = '0;
                    bcnt_n  = '0;
                    rcnt_n  = '0;
                end
                BLANK: begin
                    if (bcnt == BMAX) begin
                        state_n = SHOW;
                        bcnt_n  = '0;
                        rcnt_n  = '0;
                    end else begin
                        bcnt_n = bcnt + 1'b1;
                    end
                end
                SHOW: begin
                    if (rcnt == RMAX) begin
                        state_n = BLANK;
                        rcnt_n  = '0;
                        bcnt_n  = '0;
                        idx_n   = (idx == IMAX) ? '0 : idx + 1'b1;
                    end else begin
                        rcnt_n = rcnt + 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    idx_n   = '0;
                    bcnt_n  = '0;
                    rcnt_n  = '0;
                end
            endcase
        end
    end

    // Word swap only at frame start so a frame never mixes two words.
    always_comb begin
        accept    = upd_valid && upd_ready;
        xfer      = (state_n == BLANK) && (state != BLANK) &&
                    (idx_n == '0) && pending_full;
        active_n  = xfer ? pending : active;
        pending_n = accept ? upd_data : pending;
        pf_n      = accept ? 1'b1 : (xfer ? 1'b0 : pending_full);
    end

`ifdef SSD_LEADING_ZERO_BLANK_EN
    always_comb begin
        dark = '0;
        zr   = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zr      = zr && (active_n[4*i +: 4] == 4'd0);
            dark[i] = zr && (i != 0);
        end
    end
`endif

    always_comb begin
        nib_n = bcd_out;
        en_n  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (state_n != IDLE && idx_n == IW'(i)) begin
                nib_n = active_n[4*i +: 4];
            end
`ifdef SSD_LEADING_ZERO_BLANK_EN
            en_n[i] = (state_n == SHOW) && (idx_n == IW'(i)) && !dark[i];
`else
            en_n[i] = (state_n == SHOW) && (idx_n == IW'(i));
`endif
        end
        fd_n = (state_n == SHOW) && (rcnt_n == RMAX) && (idx_n == IMAX);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            bcnt         <= '0;
            rcnt         <= '0;
            active       <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
            upd_ready    <= 1'b1;
            bcd_out      <= 4'd0;
            digit_en     <= '0;
            frame_done   <= 1'b0;
        end else begin
            state        <= state_n;
            idx          <= idx_n;
            bcnt         <= bcnt_n;
            rcnt         <= rcnt_n;
            active       <= active_n;
            pending      <= pending_n;
            pending_full <= pf_n;
            upd_ready    <= !pf_n;
            bcd_out      <= nib_n;
            digit_en     <= en_n;
            frame_done   <= fd_n;
        end
    end

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Scoreboard bench for ssd_scan_controller (4 digits, 4-cycle dwell, 1 dark).
// Honours SSD_LEADING_ZERO_BLANK_EN when the design is built with it.
module tb_ssd_scan_controller;

`ifdef SSD_LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        upd_valid;
    logic [15:0] upd_data;
    logic        upd_ready;
    logic [3:0]  bcd_out;
    logic [3:0]  digit_en;
    logic        frame_done;

    ssd_scan_controller #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4),
        .BLANK_CYCLES(1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .upd_valid (upd_valid),
        .upd_data  (upd_data),
        .upd_ready (upd_ready),
        .bcd_out   (bcd_out),
        .digit_en  (digit_en),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] en;
        logic [3:0] bcd;
        int         len;
    } vis_t;

    vis_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_visit(input logic [3:0] en, input logic [3:0] bcd,
                              input int len);
        vis_t v;
        v.en  = en;
        v.bcd = bcd;
        v.len = len;
        sb.push_back(v);
    endtask

    // One full frame of a word; leading-zero slots stay dark when LZ is on.
    task automatic push_frame(input logic [15:0] d);
        logic [15:0] upper;
        for (int i = 0; i < 4; i++) begin
            upper = d >> (4 * i);
            if (!LZ || i == 0 || upper != 16'd0)
                push_visit(4'(1 << i), d[4*i +: 4], 4);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_fd();
        bit got = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (frame_done) begin
                got = 1'b1;
                break;
            end
        end
        chk("frame_done_seen", 32'(got), 32'd1);
    endtask

    // Monitor: each lit run is one digit visit checked against the queue.
    logic [3:0] prev_en = 4'd0;
    vis_t       cur;
    int         run_len = 0;

    always @(negedge clk) begin
        if (digit_en != 4'd0) begin
            if (prev_en == 4'd0) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_visit: got en=%b bcd=%0h want none",
                             digit_en, bcd_out);
                    cur.en  = digit_en;
                    cur.bcd = bcd_out;
                    cur.len = 4;
                end else begin
                    cur = sb.pop_front();
                    chk("visit_en", 32'(digit_en), 32'(cur.en));
                    chk("visit_bcd", 32'(bcd_out), 32'(cur.bcd));
                end
                run_len = 1;
            end else begin
                run_len++;
                chk("hold_en", 32'(digit_en), 32'(cur.en));
                chk("hold_bcd", 32'(bcd_out), 32'(cur.bcd));
            end
        end else if (prev_en != 4'd0) begin
            chk("visit_len", 32'(run_len), 32'(cur.len));
        end
        prev_en = digit_en;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int t1;
        int nfd;
        rst_n     = 1'b0;
        enable    = 1'b0;
        upd_valid = 1'b0;
        upd_data  = 16'h0;
        tick(3);
        chk("rst_ready", 32'(upd_ready), 32'd1);
        chk("rst_bcd", 32'(bcd_out), 32'd0);
        chk("rst_en", 32'(digit_en), 32'd0);
        chk("rst_fd", 32'(frame_done), 32'd0);
        rst_n = 1'b1;

        // word accepted in IDLE waits for the first frame start
        tick(1);
        upd_valid = 1'b1;
        upd_data  = 16'h1234;
        tick(1);
        upd_valid = 1'b0;
        chk("idle_ready_low", 32'(upd_ready), 32'd0);
        tick(3);
        chk("idle_en", 32'(digit_en), 32'd0);
        chk("idle_bcd", 32'(bcd_out), 32'd0);

        push_frame(16'h1234);
        push_frame(16'h1234);
        enable = 1'b1;
        c0 = cyc;
        tick(1);
        chk("first_blank_en", 32'(digit_en), 32'd0);
        chk("first_blank_bcd", 32'(bcd_out), 32'd4);
        chk("ready_after_xfer", 32'(upd_ready), 32'd1);
        wait_fd();
        chk("fd_first_time", 32'(cyc - c0), 32'd20);
        chk("fd_on_d3", 32'(digit_en), 32'h8);
        t1 = cyc;
        wait_fd();
        chk("fd_period", 32'(cyc - t1), 32'd20);

        // mid-frame update lands only at the next frame start
        push_frame(16'h1234);
        push_frame(16'h5678);
        tick(8);
        chk("ready_c7", 32'(upd_ready), 32'd1);
        upd_valid = 1'b1;
        upd_data  = 16'h5678;
        tick(1);
        chk("ready_c8", 32'(upd_ready), 32'd0);
        upd_data = 16'h9999;
        tick(7);
        chk("ready_held", 32'(upd_ready), 32'd0);
        upd_valid = 1'b0;
        wait_fd();
        chk("ready_end_frame", 32'(upd_ready), 32'd0);
        tick(1);
        chk("ready_new_frame", 32'(upd_ready), 32'd1);
        chk("new_frame_bcd", 32'(bcd_out), 32'd8);
        wait_fd();

        // enable dropped during digit 2 SHOW
        push_visit(4'b0001, 4'd8, 4);
        push_visit(4'b0010, 4'd7, 4);
        push_visit(4'b0100, 4'd6, 2);
        tick(13);
        chk("show_d2", 32'(digit_en), 32'h4);
        enable = 1'b0;
        tick(1);
        chk("drop_en", 32'(digit_en), 32'd0);
        nfd = 0;
        for (int k = 0; k < 10; k++) begin
            if (frame_done) nfd++;
            tick(1);
        end
        chk("drop_no_fd", 32'(nfd), 32'd0);

        push_visit(4'b0001, 4'd8, 4);
        push_visit(4'b0010, 4'd7, 2);
        enable = 1'b1;
        tick(1);
        chk("reen_blank_en", 32'(digit_en), 32'd0);
        chk("reen_blank_bcd", 32'(bcd_out), 32'd8);
        tick(1);
        chk("reen_d0", 32'(digit_en), 32'h1);

        // reset mid-frame with a pending word
        upd_valid = 1'b1;
        upd_data  = 16'hABCD;
        tick(1);
        upd_valid = 1'b0;
        chk("pend_full", 32'(upd_ready), 32'd0);
        tick(5);
        chk("show_d1", 32'(digit_en), 32'h2);
        rst_n  = 1'b0;
        enable = 1'b0;
        tick(1);
        chk("mid_rst_ready", 32'(upd_ready), 32'd1);
        chk("mid_rst_en", 32'(digit_en), 32'd0);
        chk("mid_rst_bcd", 32'(bcd_out), 32'd0);
        chk("mid_rst_fd", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        tick(2);
        chk("post_rst_idle", 32'(digit_en), 32'd0);

        push_frame(16'h0000);
        enable = 1'b1;
        tick(1);
        chk("post_rst_bcd", 32'(bcd_out), 32'd0);
        tick(3);
        upd_valid = 1'b1;
        upd_data  = 16'h0070;
        tick(1);
        upd_valid = 1'b0;
        wait_fd();
        chk("fd_zero_en", 32'(digit_en), LZ ? 32'h0 : 32'h8);
        push_frame(16'h0070);
        wait_fd();
        chk("fd_0070_en", 32'(digit_en), LZ ? 32'h0 : 32'h8);
        enable = 1'b0;
        tick(3);
        chk("end_dark", 32'(digit_en), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ssd_scan_controller.md
# ssd_scan_controller

Time-multiplexed scan controller that shares one `SevenSegmentDisplay` decoder across `NUM_DIGITS` common-anode/cathode digit positions. It holds a double-buffered BCD word, presents one nibble at a time to the shared decoder's `inputA..inputD`, and drives a one-hot digit-enable bus with a programmable dwell and a dark guard interval that prevents ghosting. It sits between the system's value producer, through a valid/ready update port, and the decoder plus digit drivers.

## Interface
- `NUM_DIGITS`, 4: number of digit positions. Must be at least 2. Digit 0 is least significant.
- `REFRESH_DIV`, 1000: clock cycles each digit is lit per visit. Must be at least 1.
- `BLANK_CYCLES`, 2: dark cycles before each digit visit. Must be at least 1.
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst_n`, input, 1: synchronous active-low reset. Sampled on the rising edge of `clk`.
- `enable`, input, 1: scan enable.
- `upd_valid`, input, 1: new display word offered.
- `upd_data`, input, 4*NUM_DIGITS: BCD nibbles. Digit i is bits [4i+3:4i].
- `upd_ready`, output, 1: pending buffer empty; the update is accepted when `upd_valid && upd_ready`.
- `bcd_out`, output, 4: nibble to the decoder. Bit 3 drives `inputA`, bit 0 drives `inputD`.
- `digit_en`, output, NUM_DIGITS: one-hot active-high digit select. All zero when dark.
- `frame_done`, output, 1: one-cycle pulse at the end of each full scan.

## Operation
- Buffers:
  - `pending` register plus `pending_full` flag.
  - `active` register feeding the scan.
  - An accepted update writes `pending` and sets `pending_full`.
- `upd_ready` is a registered signal equal to `!pending_full`. A second update is held off until `pending` has transferred.
- States:
  - IDLE: `digit_en` is 0. `bcd_out` holds its value.
  - BLANK: counts `BLANK_CYCLES`. `digit_en` is 0 and `bcd_out` = active[idx].
  - SHOW: counts `REFRESH_DIV`. `digit_en[idx]` is 1.
- Transitions:
  - IDLE goes to BLANK with idx=0 when `enable`=1.
  - BLANK goes to SHOW after its last cycle.
  - SHOW goes to BLANK with idx+1 after its last cycle. idx wraps from `NUM_DIGITS`-1 to 0.
  - Any state goes to IDLE when `enable`=0. This takes priority over all other transitions. idx and counters clear.
- Frame-start transfer:
  - On entry to BLANK with idx=0, if `pending_full`=1, `active` gets `pending` and `pending_full` clears.
  - The transfer only happens here, so a word never changes mid-frame.
- Updates accepted during IDLE wait for the first frame start.
- Nibbles 10–15 pass through unchanged. Decoding them is the decoder's concern.
- Counter widths: $clog2 of the respective parameter. idx width: $clog2(NUM_DIGITS).

## Timing
- Reset values:
  - state IDLE, idx 0, counters 0.
  - `active`=0, `pending`=0, `pending_full`=0.
  - `upd_ready`=1, `bcd_out`=0, `digit_en`=0, `frame_done`=0.
- All outputs are registered. `enable` rising at edge N puts the block in BLANK idx 0 after edge N+1. The first SHOW `digit_en` is visible `BLANK_CYCLES` cycles later.
- Frame length is NUM_DIGITS*(BLANK_CYCLES+REFRESH_DIV) cycles.
- `frame_done` is high during the last SHOW cycle of idx `NUM_DIGITS`-1 only.
- `upd_ready` falls the cycle after acceptance. It rises the cycle after the frame-start transfer.
- Update accepted in the same cycle as a frame-start entry: the transfer sees the old `pending_full`=0, so the word transfers at the next frame start.
- `enable` low mid-SHOW: `digit_en`=0 after the next edge and `frame_done` is not pulsed. Re-enable restarts at idx 0.
- `rst_n` low mid-frame: all reset values after that edge. Buffered words are discarded.

## Configuration
- Macro `SSD_LEADING_ZERO_BLANK_EN`.
- Defined:
  - During SHOW, `digit_en[idx]` is forced to 0 when every nibble from idx up to `NUM_DIGITS`-1 in `active` is 0 and idx is not 0.
  - Timing, `bcd_out` and `frame_done` are unchanged.
  - Digit 0 is always lit.
- Undefined: every digit is lit in its SHOW slot.

## Test plan
All scenarios use `NUM_DIGITS`=4, `REFRESH_DIV`=4 and `BLANK_CYCLES`=1, giving a 20-cycle frame.

- Reset, then accept 16'h1234 while in IDLE, then raise `enable`.
  - `digit_en` goes 0001, 0010, 0100, 1000, each lit for 4 cycles with 1 dark cycle before each.
  - `bcd_out` is 4, 3, 2, 1.
  - `frame_done` pulses every 20 cycles.
  - `upd_ready` returns to 1 after the first transfer.
- Scan 16'h1234, then offer 16'h5678 at cycle 7 of a frame.
  - Accepted at cycle 7. `upd_ready`=0 from cycle 8.
  - 16'h9999 is held off while `upd_ready`=0.
  - The remaining digits still show 2, 1.
  - The next frame shows 8, 7, 6, 5.
- Drop `enable` during the SHOW of digit 2.
  - `digit_en`=0 next cycle with no `frame_done` pulse.
  - Re-enable gives BLANK idx 0, then `digit_en`=0001.
- Assert `rst_n`=0 for 1 cycle during the SHOW of digit 1 with `pending_full`=1.
  - All outputs take reset values after that edge and `upd_ready`=1.
  - After re-enable, `bcd_out`=0 for all digits.
- With `SSD_LEADING_ZERO_BLANK_EN` defined:
  - 16'h0070 lights only digits 1 and 0, showing 7 and 0. Slots 2 and 3 are dark but keep their timing.
  - 16'h0000 lights only digit 0.
  - Without the macro, all four digits are lit.
